// File: rtl/axi_slave_mem_if.sv
// AXI4 slave-memory bus bundle: the AW, W, B, AR and R channels of one port.
// The slave modport is what the memory sees; the master modport is the initiator side.
interface axi_slave_mem_if #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32
);

  // Write address channel
  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID;
  logic [31:0]                     S_AXI_AWADDR;
  logic [7:0]                      S_AXI_AWLEN;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;

  // Write data channel
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WLAST;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;

  // Write response channel
  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;

  // Read address channel
  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID;
  logic [31:0]                     S_AXI_ARADDR;
  logic [7:0]                      S_AXI_ARLEN;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;

  // Read data channel
  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RLAST;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );

endinterface

// File: rtl/axi_slave_mem.sv
// Single-beat AXI4 slave memory. Independent write and read FSMs share one
// word-addressed array. Only single-beat (LEN=0) in-range bursts touch memory;
// longer bursts are fully consumed/produced but answered with SLVERR, and
// out-of-range addresses get DECERR. Only a 32-bit data width is supported.
module axi_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MEM_WORDS          = 1024
) (
  input logic              S_AXI_ACLK,
  input logic              S_AXI_ARESET,
  axi_slave_mem_if.slave   s_axi
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam int          STRB_W    = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Saturation point of the write beat counter, one past the largest AWLEN,
  // so an over-long W burst can never wrap around and look like a match.
  localparam logic [8:0] W_CNT_MAX = 9'h100;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Write-side state
  w_state_e                    w_state_q, w_state_d;
  logic [C_S_AXI_ID_WIDTH-1:0] awid_q, awid_d;
  logic [31:0]                 awaddr_q, awaddr_d;
  logic [7:0]                  awlen_q, awlen_d;
  logic [8:0]                  w_cnt_q, w_cnt_d;
  logic [1:0]                  bresp_q, bresp_d;

  logic                          aw_ok;
  logic                          mem_we;
  logic [IDX_W-1:0]              mem_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] mem_wdata;
  logic [STRB_W-1:0]             mem_strb;

  // Read-side state
  r_state_e                      r_state_q, r_state_d;
  logic [C_S_AXI_ID_WIDTH-1:0]   rid_q, rid_d;
  logic [7:0]                    r_cnt_q, r_cnt_d;
  logic [1:0]                    rresp_q, rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic             ar_ok;
  logic [IDX_W-1:0] ar_idx;

  assign aw_ok  = ({1'b0, awaddr_q} < MEM_BYTES);
  assign ar_ok  = ({1'b0, s_axi.S_AXI_ARADDR} < MEM_BYTES);
  assign ar_idx = s_axi.S_AXI_ARADDR[IDX_W+1:2];

  // Write FSM next state; memory is only committed on the WLAST beat once the
  // whole burst is known to be a legal single beat, so errors leave it untouched.
  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    w_cnt_d   = w_cnt_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    mem_idx   = awaddr_q[IDX_W+1:2];
    mem_wdata = s_axi.S_AXI_WDATA;
    mem_strb  = s_axi.S_AXI_WSTRB;

    unique case (w_state_q)
      W_IDLE: begin
        if (s_axi.S_AXI_AWVALID) begin
          awid_d    = s_axi.S_AXI_AWID;
          awaddr_d  = s_axi.S_AXI_AWADDR;
          awlen_d   = s_axi.S_AXI_AWLEN;
          w_cnt_d   = 9'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi.S_AXI_WVALID) begin
          if (s_axi.S_AXI_WLAST) begin
            if (!aw_ok) begin
              bresp_d = RESP_DECERR;
            end else if ((awlen_q != 8'd0) || (w_cnt_q != {1'b0, awlen_q})) begin
              bresp_d = RESP_SLVERR;
            end else begin
              bresp_d = RESP_OKAY;
              mem_we  = 1'b1;
            end
            w_state_d = W_RESP;
          end else if (w_cnt_q != W_CNT_MAX) begin
            w_cnt_d = w_cnt_q + 9'd1;
          end
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Write FSM registers
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      w_cnt_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      w_cnt_q   <= w_cnt_d;
      bresp_q   <= bresp_d;
    end
  end

  // Byte-strobed memory write; contents deliberately survive reset
  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we && !S_AXI_ARESET) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (mem_strb[b]) begin
          mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read FSM next state; the response and data are fixed at the AR handshake,
  // so RDATA sees memory as it was before that edge
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    r_cnt_d   = r_cnt_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    unique case (r_state_q)
      R_IDLE: begin
        if (s_axi.S_AXI_ARVALID) begin
          rid_d   = s_axi.S_AXI_ARID;
          r_cnt_d = s_axi.S_AXI_ARLEN;
          if (!ar_ok) begin
            rresp_d = RESP_DECERR;
            rdata_d = '0;
          end else if (s_axi.S_AXI_ARLEN != 8'd0) begin
            rresp_d = RESP_SLVERR;
            rdata_d = '0;
          end else begin
            rresp_d = RESP_OKAY;
            rdata_d = mem[ar_idx];
          end
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          if (r_cnt_q == 8'd0) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_cnt_q - 8'd1;
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Read FSM registers
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      r_cnt_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      r_cnt_q   <= r_cnt_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Outputs are forced low for as long as reset is held, not just after the
  // first reset edge, and come straight from state so they cannot glitch
  // while a handshake is stalled
  assign s_axi.S_AXI_AWREADY = !S_AXI_ARESET && (w_state_q == W_IDLE);
  assign s_axi.S_AXI_WREADY  = !S_AXI_ARESET && (w_state_q == W_DATA);
  assign s_axi.S_AXI_BVALID  = !S_AXI_ARESET && (w_state_q == W_RESP);
  assign s_axi.S_AXI_BID     = S_AXI_ARESET ? '0 : awid_q;
  assign s_axi.S_AXI_BRESP   = S_AXI_ARESET ? '0 : bresp_q;

  assign s_axi.S_AXI_ARREADY = !S_AXI_ARESET && (r_state_q == R_IDLE);
  assign s_axi.S_AXI_RVALID  = !S_AXI_ARESET && (r_state_q == R_DATA);
  assign s_axi.S_AXI_RLAST   = !S_AXI_ARESET && (r_state_q == R_DATA) && (r_cnt_q == 8'd0);
  assign s_axi.S_AXI_RID     = S_AXI_ARESET ? '0 : rid_q;
  assign s_axi.S_AXI_RRESP   = S_AXI_ARESET ? '0 : rresp_q;
  assign s_axi.S_AXI_RDATA   = S_AXI_ARESET ? '0 : rdata_q;

endmodule
